// File: rtl/mux16_sched_pkg.sv
// Shared types and constants for the 16-way round-robin mux scheduler.
package mux16_sched_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } sched_state_t;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux16_rr_sched_if.sv
// Request/grant/select bundle between the requesters, the mux16x1 select inputs
// and the downstream consumer. The scheduler uses the slave view.
interface mux16_rr_sched_if;
    import mux16_sched_pkg::*;

    logic [N_REQ-1:0] REQ;
    logic             OUT_READY;
    logic             S0;
    logic             S1;
    logic             S2;
    logic             S3;
    logic [N_REQ-1:0] GNT;
    logic             OUT_VALID;
    logic             BUSY;

    modport slave (
        input  REQ,
        input  OUT_READY,
        output S0,
        output S1,
        output S2,
        output S3,
        output GNT,
        output OUT_VALID,
        output BUSY
    );

    modport master (
        output REQ,
        output OUT_READY,
        input  S0,
        input  S1,
        input  S2,
        input  S3,
        input  GNT,
        input  OUT_VALID,
        input  BUSY
    );

endinterface

// File: rtl/mux16_rr_sched_rr_pick.sv
// Combinational round-robin pick: rotate requests so the scan starts after
// last_ptr, priority-encode the lowest set bit, then rotate the index back.
module rr_pick
    import mux16_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             last_ptr,
    output sel_t             winner,
    output logic             any
);

    sel_t             start;
    sel_t             off;
    logic [N_REQ-1:0] rot;

    always_comb begin
        start = last_ptr + 1'b1;
        rot   = (req >> start) | (req << (5'd16 - {1'b0, start}));
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = sel_t'(i);
            end
        end
        winner = start + off;
        any    = |req;
    end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 mux among 16 requesters, holding each
// grant for at most MAX_BEATS accepted beats with an idle bubble between grants.
module mux16_rr_sched
    import mux16_sched_pkg::*;
#(
    parameter int N_REQ_P   = N_REQ,
    parameter int MAX_BEATS = 8
) (
    input  logic               CLK,
    input  logic               RSTN,
    mux16_rr_sched_if.slave    bus
);

    if (N_REQ_P != 16 || MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_bad_param
        $error("mux16_rr_sched: N_REQ must be 16 and MAX_BEATS in 1..255");
    end

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

    sched_state_t     state_q, state_d;
    sel_t             sel_q, sel_d;
    sel_t             last_q, last_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [7:0]       beat_q, beat_d;

    sel_t             winner;
    logic             any;
    logic             busy;
    logic             out_valid;
    logic             beat_acc;

    rr_pick u_pick (
        .req      (bus.REQ),
        .last_ptr (last_q),
        .winner   (winner),
        .any      (any)
    );

    assign busy      = (state_q == GRANT);
    assign out_valid = busy && bus.REQ[sel_q];
    assign beat_acc  = out_valid && bus.OUT_READY;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    sel_d   = winner;
                    gnt_d   = 16'b1 << winner;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (beat_acc) begin
                    beat_d = beat_q + 8'd1;
                end
                // sel is left alone on release so the mux select never glitches
                if (!bus.REQ[sel_q] || (beat_acc && beat_q == LAST_BEAT)) begin
                    last_d  = sel_q;
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= sel_t'(N_REQ - 1);
            gnt_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            beat_q  <= beat_d;
        end
    end

    assign bus.S0        = sel_q[0];
    assign bus.S1        = sel_q[1];
    assign bus.S2        = sel_q[2];
    assign bus.S3        = sel_q[3];
    assign bus.GNT       = gnt_q;
    assign bus.OUT_VALID = out_valid;
    assign bus.BUSY      = busy;

    a_gnt_onehot: assert property (
        @(posedge CLK) disable iff (!RSTN) $onehot0(gnt_q));

    a_gnt_busy: assert property (
        @(posedge CLK) disable iff (!RSTN) gnt_q[sel_q] == busy);

    a_sel_hold: assert property (
        @(posedge CLK) disable iff (!RSTN)
        busy && $past(busy) |-> $stable(sel_q));

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Random and directed stimulus on two schedulers (MAX_BEATS 8 and 1), checked
// against a behavioural round-robin model.
module tb_mux16_rr_sched;

    logic        CLK;
    logic        RSTN;
    logic [15:0] req;
    logic        rdy;

    int n_chk;
    int n_err;

    bit m_gnt   [2];
    int m_sel   [2];
    int m_last  [2];
    int m_beats [2];
    int m_max   [2];

    mux16_rr_sched_if bus8 ();
    mux16_rr_sched_if bus1 ();

    assign bus8.REQ       = req;
    assign bus8.OUT_READY = rdy;
    assign bus1.REQ       = req;
    assign bus1.OUT_READY = rdy;

    mux16_rr_sched #(.MAX_BEATS(8)) u_dut8 (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus8)
    );

    mux16_rr_sched #(.MAX_BEATS(1)) u_dut1 (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_gnt[k]   = 1'b0;
            m_sel[k]   = 0;
            m_last[k]  = 15;
            m_beats[k] = 0;
        end
    endfunction

    // One clock edge of the arbitration rules, evaluated on current inputs.
    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            if (!m_gnt[k]) begin
                if (req != 16'h0) begin
                    bit found = 1'b0;
                    for (int j = 1; j <= 16; j++) begin
                        int c = (m_last[k] + j) % 16;
                        if (!found && req[c]) begin
                            found    = 1'b1;
                            m_sel[k] = c;
                        end
                    end
                    m_gnt[k]   = 1'b1;
                    m_beats[k] = 0;
                end
            end else begin
                if (req[m_sel[k]] && rdy) m_beats[k]++;
                if (!req[m_sel[k]] || m_beats[k] == m_max[k]) begin
                    m_gnt[k]  = 1'b0;
                    m_last[k] = m_sel[k];
                end
            end
        end
    endfunction

    task automatic cmp_dut(input string tag, input int k,
                           input logic [15:0] gnt, input logic [3:0] s,
                           input logic v, input logic b);
        logic [15:0] eg;
        eg = m_gnt[k] ? (16'h1 << m_sel[k]) : 16'h0;
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check({tag, "_sel"}, 32'(s), 32'(m_sel[k]));
        check({tag, "_valid"}, 32'(v), 32'(m_gnt[k] && req[m_sel[k]]));
        check({tag, "_busy"}, 32'(b), 32'(m_gnt[k]));
    endtask

    task automatic cmp_all(input string tag);
        cmp_dut({tag, "_m8"}, 0, bus8.GNT,
                {bus8.S3, bus8.S2, bus8.S1, bus8.S0}, bus8.OUT_VALID, bus8.BUSY);
        cmp_dut({tag, "_m1"}, 1, bus1.GNT,
                {bus1.S3, bus1.S2, bus1.S1, bus1.S0}, bus1.OUT_VALID, bus1.BUSY);
    endtask

    task automatic cycle(input string tag);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        cmp_all(tag);
    endtask

    task automatic cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic sync_reset();
        @(negedge CLK);
        RSTN = 1'b0;
        model_reset();
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    // Async reset a couple of time units after an edge, checked before the next edge.
    task automatic async_reset(input string tag);
        @(posedge CLK);
        model_step();
        #2;
        RSTN = 1'b0;
        #1;
        model_reset();
        cmp_all(tag);
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        m_max[0] = 8;
        m_max[1] = 1;
        req      = 16'h0;
        rdy      = 1'b0;
        RSTN     = 1'b0;
        model_reset();
        #12;
        cmp_all("reset");
        @(negedge CLK);
        RSTN = 1'b1;
        cycles("idle", 2);

        // single requester, 8-beat bursts with one idle bubble
        req = 16'h0001;
        rdy = 1'b1;
        cycle("t1");
        check("t1_first_gnt", 32'(bus8.GNT), 32'h0001);
        cycles("t1", 24);

        // all requesting: rotation 0..15,0 on the MAX_BEATS=1 instance
        sync_reset();
        req = 16'hFFFF;
        for (int g = 0; g < 17; g++) begin
            cycle("t2");
            check("t2_order", 32'(bus1.GNT), 32'(16'h1 << (g % 16)));
            cycle("t2");
        end
        cycles("t2", 40);

        // wrap: last_ptr=15 after reset
        sync_reset();
        req = 16'h8001;
        cycle("t3");
        check("t3_wrap", 32'(bus1.GNT), 32'h0001);
        cycles("t3", 30);

        // stall with READY low, select must hold
        req = 16'h0;
        cycles("t4", 3);
        req = 16'h0020;
        rdy = 1'b0;
        cycles("t4", 20);
        check("t4_hold", 32'(bus8.GNT), 32'h0020);
        rdy = 1'b1;
        cycles("t4", 12);

        // requester drops mid-grant
        req = 16'h0;
        cycles("t5", 3);
        req = 16'h0008;
        cycles("t5", 3);
        req = 16'h0014;
        cycles("t5", 6);

        // random traffic with async resets mixed in
        req = 16'h0;
        for (int i = 0; i < 800; i++) begin
            cycle("rnd");
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            end
            if ((i / 50) % 4 == 3) rdy = 1'b0;
            else rdy = ($urandom_range(0, 3) != 0);
            if (i == 300 || i == 600) begin
                req = 16'hFFFF;
                rdy = 1'b0;
                cycles("rnd_pre", 3);
                async_reset("async");
                rdy = 1'b1;
                req = 16'h0300;
                cycle("t6");
                check("t6_gnt8", 32'(bus8.GNT), 32'h0100);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
